// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and the
// default bubble instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_e;

  // MIPS sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a valid bit plus instruction / PC+4 / PC payload.
// Clearing drops the valid bit and parks the instruction at the NOP value.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_VALUE   = INSTR_WIDTH'(MIPS_NOP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0]  pc4_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic                   valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc4_o,
  output logic [ADDR_WIDTH-1:0]  pc_o
);

  logic                   valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc4_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  // PC fields keep their last value on clear; only the instruction is forced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_VALUE;
      pc4_q   <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_VALUE;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Fetch/decode stage register with ready/valid handshake, flush, global
// enable freeze, optional one-entry skid buffer and a saturating bubble counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_VALUE   = INSTR_WIDTH'(MIPS_NOP),
  parameter bit                     SKID        = 1'b1,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] Instruction_In,
  input  logic [ADDR_WIDTH-1:0]  PC_4_In,
  input  logic [ADDR_WIDTH-1:0]  PC,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] Instruction_Out,
  output logic [ADDR_WIDTH-1:0]  PC_4_Out,
  output logic [ADDR_WIDTH-1:0]  PC_Out,
  output logic [CNT_WIDTH-1:0]   bubble_count
);

  pipe_state_e state_q, state_d;

  logic in_xfer, out_xfer;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic                   main_valid, skid_valid;
  logic [INSTR_WIDTH-1:0] main_instr, skid_instr, main_instr_in;
  logic [ADDR_WIDTH-1:0]  main_pc4, skid_pc4, main_pc4_in;
  logic [ADDR_WIDTH-1:0]  main_pc, skid_pc, main_pc_in;

  logic [CNT_WIDTH-1:0] bubble_q, bubble_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready & enable;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (enable) begin
      if (flush) begin
        state_d    = PS_EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          PS_EMPTY: begin
            if (in_xfer) begin
              main_load = 1'b1;
              state_d   = PS_FULL;
            end
          end
          PS_FULL: begin
            if (in_xfer && out_xfer) begin
              main_load = 1'b1;
            end else if (in_xfer && SKID) begin
              skid_load = 1'b1;
              state_d   = PS_SKID;
            end else if (out_xfer) begin
              main_clear = 1'b1;
              state_d    = PS_EMPTY;
            end
          end
          PS_SKID: begin
            // Older beat leaves, skid entry slides into main on the same edge.
            if (out_xfer) begin
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clear     = 1'b1;
              state_d        = PS_FULL;
            end
          end
          default: begin
            state_d    = PS_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (enable && !main_valid && (bubble_q != {CNT_WIDTH{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PS_EMPTY;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
    end
  end

  assign main_instr_in = main_from_skid ? skid_instr : Instruction_In;
  assign main_pc4_in   = main_from_skid ? skid_pc4   : PC_4_In;
  assign main_pc_in    = main_from_skid ? skid_pc    : PC;

  pipe_entry_reg #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NOP_VALUE   (NOP_VALUE)
  ) main_u (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .instr_i (main_instr_in),
    .pc4_i   (main_pc4_in),
    .pc_i    (main_pc_in),
    .valid_o (main_valid),
    .instr_o (main_instr),
    .pc4_o   (main_pc4),
    .pc_o    (main_pc)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      pipe_entry_reg #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NOP_VALUE   (NOP_VALUE)
      ) skid_u (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (Instruction_In),
        .pc4_i   (PC_4_In),
        .pc_i    (PC),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc4_o   (skid_pc4),
        .pc_o    (skid_pc)
      );

      // Ready comes from a flop so out_ready never reaches in_ready combinationally.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != PS_SKID);
        end
      end

      assign in_ready = reset & enable & in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_instr = NOP_VALUE;
      assign skid_pc4   = '0;
      assign skid_pc    = '0;
      assign in_ready   = reset & enable & (!main_valid | out_ready);
    end
  endgenerate

  assign out_valid       = main_valid;
  assign Instruction_Out = main_instr;
  assign PC_4_Out        = main_pc4;
  assign PC_Out          = main_pc;
  assign bubble_count    = bubble_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised fetch/decode pipeline stage register carrying instruction, PC+4 and PC, with a valid bit and a ready/valid handshake on both sides.
- Adds flush (bubble insertion), a global enable freeze and an optional one-entry skid buffer, so stalls do not need a combinational ready path back through fetch.
- Keeps a saturating bubble counter for pipeline-efficiency debug.
- Instantiated between instruction fetch and decode. Also reusable for later stage boundaries.

Parameters:
- INSTR_WIDTH, 32, width of instruction channel
- ADDR_WIDTH, 32, width of PC and PC+4 channels
- NOP_VALUE, 32'h0000_0000, instruction value presented when the stage holds no valid entry (MIPS sll $0,$0,0)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready
- CNT_WIDTH, 16, width of bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- enable  in  1  1 = stage operates; 0 = freeze all state; in_ready=0, out_valid held
- flush  in  1  synchronous; discard all held entries
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- Instruction_In  in  INSTR_WIDTH  fetched instruction
- PC_4_In  in  ADDR_WIDTH  PC+4 of fetched instruction
- PC  in  ADDR_WIDTH  PC of fetched instruction
- out_valid  out  1  Instruction_Out/PC_4_Out/PC_Out valid
- out_ready  in  1  downstream accepts beat
- Instruction_Out  out  INSTR_WIDTH  registered instruction
- PC_4_Out  out  ADDR_WIDTH  registered PC+4
- PC_Out  out  ADDR_WIDTH  registered PC
- bubble_count  out  CNT_WIDTH  saturating count of enabled cycles with out_valid=0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low.
- Reset (reset=0): main and skid entries invalid; out_valid=0; Instruction_Out=NOP_VALUE; PC_4_Out=0; PC_Out=0; bubble_count=0; in_ready=0 while reset asserted.
  - First cycle after release: in_ready=1.
- Transfers:
  - Upstream transfer = in_valid & in_ready & enable.
  - Downstream transfer = out_valid & out_ready & enable.
- Latency: 1 cycle from upstream transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- States (SKID=1): EMPTY, FULL (main valid), SKIDDED (main+skid valid). in_ready = (state != SKIDDED), registered.
  - EMPTY --in xfer--> FULL.
  - FULL --in & out xfer--> FULL (main reloaded).
  - FULL --out only--> EMPTY.
  - FULL --in only--> SKIDDED (beat into skid).
  - SKIDDED --out xfer--> FULL (skid moves to main, same edge).
  - SKIDDED: no upstream transfer possible.
- SKID=0: states EMPTY/FULL only; in_ready = enable & (!out_valid | out_ready), combinational.
- Ordering: beats leave in acceptance order; no duplication, no loss except by flush.
- Output when out_valid=0: Instruction_Out=NOP_VALUE. PC_4_Out/PC_Out hold last value (don't-care for checking).
- flush=1 at an enabled edge:
  - All entries invalid → EMPTY; Instruction_Out=NOP_VALUE.
  - A simultaneous upstream beat is discarded (flush beats load).
  - flush with enable=0 is ignored.
- enable=0: no state change, outputs held, counter held; in_ready driven 0.
- bubble_count: increments on each enabled edge where out_valid=0 (pre-edge value); saturates at 2^CNT_WIDTH-1; cleared only by reset.
- Reset mid-operation: immediate return to reset values regardless of state; beats in flight are lost.
- All registers update on posedge clk only (no negedge logic).

Decomposition:
- Shared package pipe_pkg:
  - state encoding (PS_EMPTY=2'd0, PS_FULL=2'd1, PS_SKID=2'd2)
  - default NOP_VALUE constant MIPS_NOP
- One natural sub-module: pipe_entry_reg (valid bit + three payload registers with load/clear), instantiated for main and skid entries.
- Counter is inline.

Test Plan:
- Reset then stream 0x2402000A/0x24030005 at PC 0x0,0x4 with out_ready=1 → out_valid one cycle after each accept, PC_4_Out=0x4,0x8, bubble_count=1 (first cycle only).
- SKID=1: accept A, deassert out_ready, present B → B accepted into skid, in_ready falls next cycle. Reassert out_ready → A then B delivered on consecutive cycles, no loss.
- flush asserted in SKIDDED with in_valid=1 → next cycle out_valid=0, Instruction_Out=0x00000000, in_ready=1, incoming beat not delivered.
- enable=0 for 3 cycles mid-stream with in_valid=1 → outputs and bubble_count frozen, in_ready=0, stream resumes unchanged.
- CNT_WIDTH=4, in_valid=0 for 20 cycles → bubble_count saturates at 15.
- Assert reset asynchronously mid-cycle in FULL → outputs immediately 0/NOP, out_valid=0 before next clk edge.
